calc_arbiter: RTL and testbench

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_arbiter.sv | 120 ++++++++++++
 tb/tb_calc_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// Two-requester round-robin front end sharing one add/sub/abs datapath (IDLE -> CALC -> RESP).
// Define CALC_ARB_OVF_STICKY_EN to add the sticky overflow flag (ovf_sticky/ovf_clr).
module calc_arbiter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
`ifdef CALC_ARB_OVF_STICKY_EN
  output logic         ovf_sticky,
  input  logic         ovf_clr,
`endif
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_r,
  output logic         rsp_ovf
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e       state_q;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         id_q;
  logic         prio_q;  // 1: req1 wins a tie (req0 was served last)

  logic         gnt_id;
  logic [W-1:0] x, y, sum, abs_src, abs_r, dp_r;
  logic         add_ovf, abs_ovf, dp_ovf;

  // Readies are gated by rst_n so that every output is 0 while reset is asserted.
  always_comb begin
    gnt_id     = req1_valid & (~req0_valid | prio_q);
    req0_ready = rst_n & (state_q == StIdle) & req0_valid & ~gnt_id;
    req1_ready = rst_n & (state_q == StIdle) & req1_valid & gnt_id;
  end

  // Shared datapath: op[2] swaps operand order, op[1] selects abs.
  always_comb begin
    x = op_q[2] ? b_q : a_q;
    y = op_q[2] ? a_q : b_q;
    sum = op_q[0] ? (x - y) : (x + y);
    if (op_q[0]) begin
      add_ovf = (x[W-1] != y[W-1]) && (sum[W-1] != x[W-1]);
    end else begin
      add_ovf = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    end
    abs_src = op_q[2] ? a_q : b_q;
    abs_r   = abs_src[W-1] ? (-abs_src) : abs_src;
    abs_ovf = abs_src[W-1] & ~(|abs_src[W-2:0]);
    dp_r    = op_q[1] ? abs_r : sum;
    dp_ovf  = op_q[1] ? abs_ovf : add_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      prio_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0_valid | req1_valid) begin
            id_q    <= gnt_id;
            op_q    <= gnt_id ? req1_op : req0_op;
            a_q     <= gnt_id ? req1_a : req0_a;
            b_q     <= gnt_id ? req1_b : req0_b;
            prio_q  <= ~gnt_id;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          rsp_r     <= dp_r;
          rsp_ovf   <= dp_ovf;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CALC_ARB_OVF_STICKY_EN
  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (rsp_valid & rsp_ready & rsp_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: directed literal checks plus randomized traffic
// compared each cycle against a transaction-level model.
module tb_calc_arbiter;
  localparam int W = 16;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [W-1:0] rsp_r;
`ifdef CALC_ARB_OVF_STICKY_EN
  logic         ovf_sticky, ovf_clr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  calc_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef CALC_ARB_OVF_STICKY_EN
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_ovf    (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Exact integer arithmetic, then wrap; overflow is "true result out of range".
  function automatic void model_calc(input logic [2:0] op, input logic [15:0] a,
                                     input logic [15:0] b, output logic [15:0] r,
                                     output logic ovf);
    int sa, sb, full;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0:       full = sa + sb;
      3'd1:       full = sa - sb;
      3'd2, 3'd3: full = (sb < 0) ? -sb : sb;
      3'd4:       full = sb + sa;
      3'd5:       full = sb - sa;
      default:    full = (sa < 0) ? -sa : sa;
    endcase
    r   = full[15:0];
    ovf = (full > 32767) || (full < -32768);
  endfunction

  // Transaction-level model: one outstanding op, response due 2 cycles after accept.
  int          cyc = 0;
  bit          have = 0;
  int          acc_cyc = 0;
  int          last = 1;
  logic [15:0] exp_r;
  logic        exp_ovf, exp_id;
  bit          sticky_m = 0;

  always @(negedge clk) begin
    int g;
    bit erv, hs;
    cyc++;
    if (!rst_n) begin
      have = 0;
      last = 1;
      sticky_m = 0;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_r", rsp_r, 0);
      chk("rst_rsp_ovf", rsp_ovf, 0);
      chk("rst_rsp_id", rsp_id, 0);
`ifdef CALC_ARB_OVF_STICKY_EN
      chk("rst_sticky", ovf_sticky, 0);
`endif
    end else begin
`ifdef CALC_ARB_OVF_STICKY_EN
      chk("sticky", ovf_sticky, sticky_m);
`endif
      hs = 0;
      if (!have) begin
        g = -1;
        if (req0_valid && req1_valid) g = (last == 0) ? 1 : 0;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("rsp_valid_idle", rsp_valid, 0);
        if (g >= 0) begin
          have = 1;
          acc_cyc = cyc;
          last = g;
          exp_id = (g == 1);
          if (g == 0) model_calc(req0_op, req0_a, req0_b, exp_r, exp_ovf);
          else model_calc(req1_op, req1_a, req1_b, exp_r, exp_ovf);
        end
      end else begin
        erv = (cyc >= acc_cyc + 2);
        chk("ready0_busy", req0_ready, 0);
        chk("ready1_busy", req1_ready, 0);
        chk("rsp_valid", rsp_valid, erv);
        if (erv) begin
          chk("rsp_r", rsp_r, exp_r);
          chk("rsp_ovf", rsp_ovf, exp_ovf);
          chk("rsp_id", rsp_id, exp_id);
          hs = rsp_ready;
          if (hs) have = 0;
        end
      end
`ifdef CALC_ARB_OVF_STICKY_EN
      if (hs && exp_ovf) sticky_m = 1;
      else if (ovf_clr) sticky_m = 0;
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit acc0, acc1;
    rst_n = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1;
`ifdef CALC_ARB_OVF_STICKY_EN
    ovf_clr = 0;
`endif
    step(3);
    rst_n = 1;
    step(1);

    // Both valid continuously: grants alternate starting with req0.
    req0_valid = 1; req0_op = 3'b110; req0_a = 16'h8000; req0_b = 16'h1234;
    req1_valid = 1; req1_op = 3'b010; req1_a = 16'h4321; req1_b = 16'd7;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("alt_ready0", req0_ready, (k % 2) == 0);
      chk("alt_ready1", req1_ready, (k % 2) == 1);
      step(2);
      chk("alt_r", rsp_r, (k % 2 == 0) ? 16'h8000 : 16'd7);
      chk("alt_ovf", rsp_ovf, (k % 2) == 0);
      chk("alt_id", rsp_id, k % 2);
      step(1);
    end
    req0_valid = 0; req1_valid = 0;
    step(2);

    // 100 + (-30) = 70 on req0, 2-cycle latency, valid for one cycle.
    req0_valid = 1; req0_op = 3'b000; req0_a = 16'd100; req0_b = -16'sd30;
    #1;
    chk("add_ready0", req0_ready, 1);
    step(1);
    req0_valid = 0;
    chk("add_calc_valid", rsp_valid, 0);
    step(1);
    chk("add_valid", rsp_valid, 1);
    chk("add_r", rsp_r, 16'd70);
    chk("add_ovf", rsp_ovf, 0);
    chk("add_id", rsp_id, 0);
    step(1);
    chk("add_valid_drop", rsp_valid, 0);

    // req1: B-A = 3-5 = -2.
    req1_valid = 1; req1_op = 3'b101; req1_a = 16'd5; req1_b = 16'd3;
    step(1);
    req1_valid = 0;
    step(1);
    chk("bsa_r", rsp_r, 16'hFFFE);
    chk("bsa_ovf", rsp_ovf, 0);
    chk("bsa_id", rsp_id, 1);
    step(1);

    // 0x7FFF + 1 overflows.
    req0_valid = 1; req0_op = 3'b000; req0_a = 16'h7FFF; req0_b = 16'd1;
    step(1);
    req0_valid = 0;
    step(1);
    chk("ovf_r", rsp_r, 16'h8000);
    chk("ovf_flag", rsp_ovf, 1);
    step(1);
`ifdef CALC_ARB_OVF_STICKY_EN
    chk("sticky_set", ovf_sticky, 1);
    ovf_clr = 1;
    step(1);
    ovf_clr = 0;
    chk("sticky_clr", ovf_sticky, 0);
`endif

    // Back-pressure: response held while rsp_ready is low.
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'b001; req0_a = 16'd9; req0_b = 16'd2;
    req1_valid = 1; req1_op = 3'b000; req1_a = 16'd3; req1_b = 16'd4;
    #1;
    chk("bp_ready1", req1_ready, 1);
    chk("bp_ready0", req0_ready, 0);
    step(1);
    req1_valid = 0;
    step(1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_r", rsp_r, 16'd7);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready0_low", req0_ready, 0);
      chk("bp_ready1_low", req1_ready, 0);
      step(1);
    end
    rsp_ready = 1;
    step(1);
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_ready0", req0_ready, 1);
    step(1);
    req0_valid = 0;
    step(3);

    // Reset in CALC drops the op; afterwards req0 wins a tie.
    req0_valid = 1; req0_op = 3'b001; req0_a = 16'd10; req0_b = 16'd3;
    step(1);
    req0_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_r", rsp_r, 0);
    chk("mid_rst_ovf", rsp_ovf, 0);
    chk("mid_rst_id", rsp_id, 0);
    @(posedge clk);
    #1;
    req0_valid = 1; req0_op = 3'b100; req0_a = 16'd1; req0_b = 16'd2;
    req1_valid = 1; req1_op = 3'b000; req1_a = 16'd3; req1_b = 16'd4;
    rst_n = 1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    chk("post_rst_valid", rsp_valid, 0);
    step(1);
    req0_valid = 0; req1_valid = 0;
    step(3);

    // Randomized traffic; the negedge model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      @(posedge clk);
      #1;
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_op = 3'($urandom);
        req0_a = rnd_opnd();
        req0_b = rnd_opnd();
      end else if ($urandom_range(0, 99) < 5) begin
        req0_valid = 0;
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_op = 3'($urandom);
        req1_a = rnd_opnd();
        req1_b = rnd_opnd();
      end else if ($urandom_range(0, 99) < 5) begin
        req1_valid = 0;
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
`ifdef CALC_ARB_OVF_STICKY_EN
      ovf_clr = ($urandom_range(0, 99) < 10);
`endif
    end

    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
`ifdef CALC_ARB_OVF_STICKY_EN
    ovf_clr = 0;
`endif
    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
